// File: rtl/matvec_mac_engine.sv
// Matrix-vector multiply-accumulate engine: streams each row of A against
// vector B from the operand RAM, accumulates the dot product, then writes the
// scaled, saturated result to the result RAM. Pulses done when all rows are
// written.
module matvec_mac_engine #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned ROWS          = 64,
    parameter int unsigned COLS          = 8,
    parameter int unsigned A_ADDR_BITS   = 9,
    parameter int unsigned B_ADDR_BITS   = 3,
    parameter int unsigned RES_ADDR_BITS = 6
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     a_read_en,
    output logic [A_ADDR_BITS-1:0]   a_read_addr,
    input  logic [WIDTH-1:0]         a_read_data,
    output logic                     b_read_en,
    output logic [B_ADDR_BITS-1:0]   b_read_addr,
    input  logic [WIDTH-1:0]         b_read_data,
    output logic                     res_write_en,
    output logic [RES_ADDR_BITS-1:0] res_write_addr,
    output logic [WIDTH-1:0]         res_write_data
);

    localparam int unsigned COL_BITS = $clog2(COLS);
    localparam int unsigned ACC_W    = 2 * WIDTH + COL_BITS;
    localparam int unsigned SHIFT_W  = ACC_W - WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [RES_ADDR_BITS-1:0] row, row_nxt;
    logic [B_ADDR_BITS-1:0]   col, col_nxt;
    logic [ACC_W-1:0]         acc, acc_nxt;
    logic                     issue_d, issue_d_nxt;

    logic                     busy_nxt;
    logic                     done_nxt;
    logic                     rd_en_nxt;
    logic [A_ADDR_BITS-1:0]   a_addr_nxt;
    logic [B_ADDR_BITS-1:0]   b_addr_nxt;
    logic                     wr_en_nxt;
    logic [RES_ADDR_BITS-1:0] wr_addr_nxt;
    logic [WIDTH-1:0]         wr_data_nxt;

    logic [ACC_W-1:0]         prod_c;
    logic [SHIFT_W-1:0]       acc_shift_c;

    // Unsigned operand product at full accumulator width.
    assign prod_c = ACC_W'(a_read_data) * ACC_W'(b_read_data);

    // Scaled value of the accumulator as it will stand entering WRITE.
    assign acc_shift_c = acc_nxt[ACC_W-1:WIDTH];

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        col_nxt     = col;
        acc_nxt     = acc;
        issue_d_nxt = issue_d;

        // Operand data lags the read issue by one cycle.
        if (issue_d) begin
            acc_nxt = acc + prod_c;
        end

        case (state)
            ST_IDLE: begin
                if (start) begin
                    row_nxt   = '0;
                    col_nxt   = '0;
                    acc_nxt   = '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                issue_d_nxt = 1'b1;
                if (col == B_ADDR_BITS'(COLS - 1)) begin
                    col_nxt   = '0;
                    state_nxt = ST_DRAIN;
                end else begin
                    col_nxt = col + B_ADDR_BITS'(1);
                end
            end
            ST_DRAIN: begin
                issue_d_nxt = 1'b0;
                state_nxt   = ST_WRITE;
            end
            ST_WRITE: begin
                acc_nxt = '0;
                if (row == RES_ADDR_BITS'(ROWS - 1)) begin
                    state_nxt = ST_DONE;
                end else begin
                    row_nxt   = row + RES_ADDR_BITS'(1);
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt    = (state_nxt != ST_IDLE);
        done_nxt    = (state_nxt == ST_DONE);
        rd_en_nxt   = (state_nxt == ST_RUN);
        a_addr_nxt  = '0;
        b_addr_nxt  = '0;
        wr_en_nxt   = (state_nxt == ST_WRITE);
        wr_addr_nxt = '0;
        wr_data_nxt = '0;

        if (rd_en_nxt) begin
            a_addr_nxt = A_ADDR_BITS'(A_ADDR_BITS'(row_nxt) * A_ADDR_BITS'(COLS)
                                      + A_ADDR_BITS'(col_nxt));
            b_addr_nxt = col_nxt;
        end

        if (wr_en_nxt) begin
            wr_addr_nxt = row_nxt;
            // Saturate when the scaled sum no longer fits one result word.
            if (|acc_shift_c[SHIFT_W-1:WIDTH]) begin
                wr_data_nxt = '1;
            end else begin
                wr_data_nxt = acc_shift_c[WIDTH-1:0];
            end
        end
    end

    // State, datapath and registered outputs; reset clears all asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            row            <= '0;
            col            <= '0;
            acc            <= '0;
            issue_d        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            a_read_en      <= 1'b0;
            a_read_addr    <= '0;
            b_read_en      <= 1'b0;
            b_read_addr    <= '0;
            res_write_en   <= 1'b0;
            res_write_addr <= '0;
            res_write_data <= '0;
        end else begin
            state          <= state_nxt;
            row            <= row_nxt;
            col            <= col_nxt;
            acc            <= acc_nxt;
            issue_d        <= issue_d_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            a_read_en      <= rd_en_nxt;
            a_read_addr    <= a_addr_nxt;
            b_read_en      <= rd_en_nxt;
            b_read_addr    <= b_addr_nxt;
            res_write_en   <= wr_en_nxt;
            res_write_addr <= wr_addr_nxt;
            res_write_data <= wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_matvec_mac_engine.sv
// Bench for matvec_mac_engine: operand RAM model, result capture, and a
// plain-arithmetic dot-product reference.
module tb_matvec_mac_engine;

    localparam int W  = 8;
    localparam int R  = 64;
    localparam int C  = 8;
    localparam int AB = 9;
    localparam int BB = 3;
    localparam int RB = 6;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          busy;
    logic          done;
    logic          a_read_en;
    logic [AB-1:0] a_read_addr;
    logic [W-1:0]  a_read_data;
    logic          b_read_en;
    logic [BB-1:0] b_read_addr;
    logic [W-1:0]  b_read_data;
    logic          res_write_en;
    logic [RB-1:0] res_write_addr;
    logic [W-1:0]  res_write_data;

    logic [30:0]   outs;

    int unsigned a_mem [R*C];
    int unsigned b_mem [C];
    int unsigned exp_res [R];
    int unsigned wr_addr_q [$];
    int unsigned wr_data_q [$];
    int          rd_idx;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    matvec_mac_engine #(
        .WIDTH(W), .ROWS(R), .COLS(C),
        .A_ADDR_BITS(AB), .B_ADDR_BITS(BB), .RES_ADDR_BITS(RB)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .busy(busy),
        .done(done),
        .a_read_en(a_read_en),
        .a_read_addr(a_read_addr),
        .a_read_data(a_read_data),
        .b_read_en(b_read_en),
        .b_read_addr(b_read_addr),
        .b_read_data(b_read_data),
        .res_write_en(res_write_en),
        .res_write_addr(res_write_addr),
        .res_write_data(res_write_data)
    );

    assign outs = {busy, done, a_read_en, a_read_addr, b_read_en, b_read_addr,
                   res_write_en, res_write_addr, res_write_data};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Operand RAM with registered read ports.
    initial begin
        a_read_data = '0;
        b_read_data = '0;
    end
    always @(posedge clk) begin
        if (a_read_en) a_read_data <= W'(a_mem[a_read_addr]);
        if (b_read_en) b_read_data <= W'(b_mem[b_read_addr]);
    end

    // Capture writes and check read sequencing / idle zeros.
    always @(negedge clk) begin
        if (resetn) begin
            if (res_write_en) begin
                wr_addr_q.push_back(int'(res_write_addr));
                wr_data_q.push_back(int'(res_write_data));
            end else begin
                check("wr_idle_zero", {res_write_addr, res_write_data}, 0);
            end
            if (a_read_en) begin
                check("a_addr", a_read_addr, rd_idx);
                check("b_addr", b_read_addr, rd_idx % C);
                check("b_en", b_read_en, 1);
                rd_idx++;
            end else begin
                check("rd_idle_zero", {b_read_en, a_read_addr, b_read_addr}, 0);
            end
        end
    end

    function automatic void compute_expected();
        for (int r = 0; r < R; r++) begin
            int unsigned sum;
            int unsigned q;
            sum = 0;
            for (int c = 0; c < C; c++) sum += a_mem[r*C + c] * b_mem[c];
            q = sum / 256;
            exp_res[r] = (q > 255) ? 255 : q;
        end
    endfunction

    task automatic fill_random();
        for (int r = 0; r < R; r++) begin
            int unsigned amax;
            amax = (r % 3 == 0) ? 255 : 63;
            for (int c = 0; c < C; c++) a_mem[r*C + c] = $urandom_range(0, amax);
        end
        for (int c = 0; c < C; c++) b_mem[c] = $urandom_range(0, 255);
    endtask

    task automatic verify_writes(input int n);
        check("wr_count", wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), wr_addr_q[i], i);
            check($sformatf("wr_data[%0d]", i), wr_data_q[i], exp_res[i]);
        end
    endtask

    task automatic do_run(input bit hold);
        int edges;
        bit seen;
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_idx = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_rise", busy, 1);
        if (!hold) start = 1'b0;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 5000) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) seen = 1'b1;
        end
        check("done_seen", seen, 1);
        check("done_latency", edges, R*(C+2));
        check("busy_at_done", busy, 1);
        @(posedge clk);
        #1;
        check("done_width", done, 0);
        check("busy_fall", busy, 0);
        if (hold) start = 1'b0;
        check("read_count", rd_idx, R*C);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        rd_idx = 0;

        // Reset and idle.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs, 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            check("idle_outs", outs, 0);
        end

        // Basic product: row 0 all 16, B all 16.
        fill_random();
        for (int c = 0; c < C; c++) begin
            a_mem[c] = 16;
            b_mem[c] = 16;
        end
        compute_expected();
        do_run(1'b0);
        verify_writes(R);
        if (wr_data_q.size() > 0) check("basic_row0", wr_data_q[0], 8);

        // Saturation: row 1 all 255, B all 255.
        fill_random();
        for (int c = 0; c < C; c++) begin
            a_mem[C + c] = 255;
            b_mem[c]     = 255;
        end
        compute_expected();
        do_run(1'b0);
        verify_writes(R);
        if (wr_data_q.size() > 1) check("sat_row1", wr_data_q[1], 255);

        // Random mixed values.
        for (int k = 0; k < 2; k++) begin
            fill_random();
            compute_expected();
            do_run(1'b0);
            verify_writes(R);
        end

        // Start held through the run and DONE: only one run.
        fill_random();
        compute_expected();
        do_run(1'b1);
        verify_writes(R);
        repeat (20) begin
            @(posedge clk);
            #1;
            check("no_second_run", {busy, done, a_read_en}, 0);
        end
        check("no_extra_writes", wr_addr_q.size(), R);

        // Reset during row 3.
        fill_random();
        compute_expected();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_idx = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3*(C+2) + 2) @(posedge clk);
        #2;
        check("abort_busy_before", busy, 1);
        resetn = 1'b0;
        #1;
        check("abort_async_outs", outs, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
            check("abort_hold_outs", outs, 0);
        end
        verify_writes(3);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            check("abort_no_done", done, 0);
        end
        fill_random();
        compute_expected();
        do_run(1'b0);
        verify_writes(R);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/matvec_mac_engine.md
Name: matvec_mac_engine

Overview:
Downstream consumer of the dual-memory operand RAM (A = matrix, row-major; B = vector). On a start pulse it streams A and B through the RAM read ports and computes one multiply-accumulate dot product per matrix row. Each row result is scaled, saturated and written to a result RAM through a single write port. It signals completion to the top-level controller, which then unloads the result RAM.

Parameters:
WIDTH, 8, bits per operand and per result word
ROWS, 64, matrix rows = number of results
COLS, 8, matrix columns = vector length (power of 2, >= 2)
A_ADDR_BITS, 9, A read address width (log2(ROWS*COLS))
B_ADDR_BITS, 3, B read address width (log2(COLS))
RES_ADDR_BITS, 6, result address width (log2(ROWS))

Ports:
clk  in  1  system clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  begin computation; sampled only in IDLE
busy  out  1  high from the cycle after start is sampled until DONE exits
done  out  1  one-cycle pulse, all results written
a_read_en  out  1  read enable to the A port of the operand RAM
a_read_addr  out  A_ADDR_BITS  A address = row*COLS + col
a_read_data  in  WIDTH  A data, registered, valid the cycle after a_read_en
b_read_en  out  1  read enable to the B port of the operand RAM
b_read_addr  out  B_ADDR_BITS  B address = col
b_read_data  in  WIDTH  B data, registered, valid the cycle after b_read_en
res_write_en  out  1  result RAM write strobe
res_write_addr  out  RES_ADDR_BITS  result index = row
res_write_data  out  WIDTH  scaled, saturated dot product

Behaviour:
- Reset: the block uses one clock, clk, and an asynchronous active-low reset, resetn. Reset forces state to IDLE and clears row, col, acc and the issue-delay flag. All outputs go to 0 immediately, without waiting for a clock edge.
- Reset mid-operation: the computation is abandoned and partial results already written stay in the result RAM. No done pulse is produced. The next start begins again from row 0.
- FSM states: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE: busy = 0. If start = 1 on a rising edge: row <= 0, col <= 0, acc <= 0, go to RUN. Otherwise stay in IDLE.
- RUN:
  - Assert a_read_en and b_read_en with a_read_addr = row*COLS + col and b_read_addr = col.
  - Set issue_d <= 1 and col <= col + 1.
  - When col == COLS-1: col <= 0 and go to DRAIN.
- DRAIN: no reads are issued; issue_d <= 0. The last operand pair is accumulated in this cycle. Go to WRITE.
- Accumulation: on any edge where issue_d = 1, acc <= acc + a_read_data * b_read_data.
  - Operands are unsigned.
  - acc width is 2*WIDTH + log2(COLS); it cannot overflow.
- WRITE:
  - res_write_en = 1, res_write_addr = row.
  - res_write_data = acc >> WIDTH, saturated to 2^WIDTH - 1 when the shifted value exceeds WIDTH bits.
  - acc <= 0.
  - If row == ROWS-1 go to DONE; otherwise row <= row + 1 and go to RUN.
- DONE: done = 1 for exactly one cycle, then go to IDLE. busy drops in the same cycle the FSM returns to IDLE.
- Latency:
  - Each row takes COLS + 2 cycles.
  - done is high ROWS*(COLS+2) rising edges after the edge that sampled start.
- Output rules:
  - busy, done and the enables are decoded from registered state; they are glitch-free.
  - Read enables and read addresses are 0 outside RUN.
  - res_write_* outputs are 0 outside WRITE.
- start while not in IDLE is ignored; there is no queuing or restart.
- Read-only use: the engine never drives the operand RAM write ports. While busy = 1, the upstream loader must not write the operand RAM; doing so is a system-level protocol error and this block does not check for it.
- Wrap-around: row and col never exceed ROWS-1 and COLS-1; address arithmetic never overflows its port width.

Test Plan:
1. Reset and idle: hold resetn = 0, then release with start = 0 for 20 cycles -> busy, done, all enables and all addresses stay 0.
2. Basic product (ROWS=2, COLS=4): A row 0 = 16,16,16,16; B = 16,16,16,16 -> write addr 0, data 4 (1024 >> 8).
3. Saturation (ROWS=2, COLS=4): A row 1 = 255 x4; B = 255 x4 -> write addr 1, data 255 (260100 >> 8 = 1016, saturated). done pulses exactly 12 edges after start is sampled, for 1 cycle.
4. Mixed values with default parameters: random A and B -> 64 writes, addresses 0..63 in order. Each write matches the reference model, and reads follow a_read_addr = row*8 + col.
5. start held high during the whole run and re-asserted during DONE -> exactly one run executes. A second run occurs only on a start sampled in IDLE.
6. Assert resetn low during row 3 of RUN -> all outputs go to 0 asynchronously and no done pulse is produced. A new start recomputes from row 0 with correct results.
